// File: rtl/stepper_move_scheduler.sv
// Step/dir pulse scheduler for one stepper axis: Avalon-MM register file, command FIFO,
// pulse-timing FSM and a wrapping signed position counter.
module stepper_move_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 8,
  parameter int DIR_SETUP  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        step_out,
  output logic        dir_out,
  output logic        enable_out,
  output logic [31:0] position,
  output logic        busy,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [31:0]   MIN_PERIOD = 32'(2 * PULSE_W);
  localparam logic [31:0]   PULSE_LAST = 32'(PULSE_W - 1);
  localparam logic [31:0]   SETUP_LAST = 32'(DIR_SETUP - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DSETUP = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] steps;
    logic [31:0] period;
    logic        dir;
  } cmd_t;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  state_t      state_r, state_nxt;
  logic [31:0] steps_r, period_r, cnt_r, rem_r, cur_period_r, pos_r, readdata_r;
  logic        dir_r, enable_r, irq_en_r, overflow_r, done_r, busy_r, irq_r;
  logic        step_r, dir_out_r;
  cmd_t        fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] count_r, count_nxt_s;

  logic        ctrl_wr_s, stat_wr_s, pos_wr_s, kill_s, push_req_s, fifo_we_s, pop_s;
  logic        full_s, empty_s, move_end_s, done_nxt_s, irq_en_nxt_s;
  logic [31:0] low_last_s, rd_mux_s;
  cmd_t        head_s, new_cmd_s;
  logic        unused_s;

  assign unused_s   = avs_read;
  assign ctrl_wr_s  = avs_write && (avs_address == 3'd2);
  assign stat_wr_s  = avs_write && (avs_address == 3'd3);
  assign pos_wr_s   = avs_write && (avs_address == 3'd4);
  // Abort, or dropping enable while it was set, stops motion and flushes queued moves.
  assign kill_s     = ctrl_wr_s && (avs_writedata[2] || (enable_r && !avs_writedata[3]));
  assign push_req_s = ctrl_wr_s && avs_writedata[1] && !kill_s;
  assign full_s     = (count_r == DEPTH_L);
  assign empty_s    = (count_r == LW'(0));
  assign fifo_we_s  = push_req_s && !full_s;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign new_cmd_s  = '{steps: steps_r, period: clamp_period(period_r), dir: avs_writedata[0]};
  assign pop_s      = (state_r == ST_IDLE) && enable_r && !empty_s && !kill_s;
  assign low_last_s = cur_period_r - 32'(PULSE_W) - 32'd1;

  // FIFO occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_nxt_s = count_r;
    if (kill_s) begin
      count_nxt_s = LW'(0);
    end else begin
      count_nxt_s = count_r + {{(LW-1){1'b0}}, fifo_we_s} - {{(LW-1){1'b0}}, pop_s};
    end
  end

  // Next-state logic for the pulse sequencer.
  always_comb begin
    state_nxt  = state_r;
    move_end_s = 1'b0;
    if (kill_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s && (head_s.steps != 32'd0)) begin
            state_nxt = (head_s.dir != dir_out_r) ? ST_DSETUP : ST_HIGH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DSETUP: begin
          if (cnt_r == SETUP_LAST) state_nxt = ST_HIGH;
          else                     state_nxt = ST_DSETUP;
        end
        ST_HIGH: begin
          if (cnt_r == PULSE_LAST) state_nxt = ST_LOW;
          else                     state_nxt = ST_HIGH;
        end
        ST_LOW: begin
          if (cnt_r != low_last_s) begin
            state_nxt = ST_LOW;
          end else if (rem_r > 32'd1) begin
            state_nxt = ST_HIGH;
          end else begin
            state_nxt  = ST_IDLE;
            move_end_s = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sticky done flag and irq enable as they will be after this cycle.
  always_comb begin
    done_nxt_s   = done_r;
    irq_en_nxt_s = irq_en_r;
    if (move_end_s && empty_s && !fifo_we_s) begin
      done_nxt_s = 1'b1;
    end else if (stat_wr_s && avs_writedata[4]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (ctrl_wr_s) irq_en_nxt_s = avs_writedata[4];
    else           irq_en_nxt_s = irq_en_r;
  end

  // Read-data address mux; unmapped addresses return zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      3'd0:    rd_mux_s = steps_r;
      3'd1:    rd_mux_s = period_r;
      3'd2:    rd_mux_s = {27'd0, irq_en_r, enable_r, 2'b00, dir_r};
      3'd3:    rd_mux_s = {16'd0, 8'(count_r), 3'd0, done_r, overflow_r, empty_s, full_s, busy_r};
      3'd4:    rd_mux_s = pos_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Sequencer state, phase counter, active move and position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 32'd0;
      rem_r        <= 32'd0;
      cur_period_r <= 32'd0;
      dir_out_r    <= 1'b0;
      step_r       <= 1'b0;
      pos_r        <= 32'd0;
    end else begin
      state_r <= state_nxt;
      if ((state_nxt != state_r) || (state_r == ST_IDLE)) cnt_r <= 32'd0;
      else                                                 cnt_r <= cnt_r + 32'd1;
      if (pop_s) begin
        rem_r        <= head_s.steps;
        cur_period_r <= head_s.period;
      end else if ((state_r == ST_LOW) && (state_nxt == ST_HIGH)) begin
        rem_r <= rem_r - 32'd1;
      end
      if (pop_s && (head_s.steps != 32'd0)) dir_out_r <= head_s.dir;
      step_r <= (state_nxt == ST_HIGH);
      // A register write takes priority over a coincident step.
      if (pos_wr_s) begin
        pos_r <= avs_writedata;
      end else if ((state_nxt == ST_HIGH) && (state_r != ST_HIGH)) begin
        pos_r <= pos_r + (dir_out_r ? 32'd1 : 32'hFFFF_FFFF);
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      count_r <= count_nxt_s;
      if (kill_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (fifo_we_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // FIFO storage; contents are meaningless while unoccupied.
  always_ff @(posedge clk) begin
    if (fifo_we_s) fifo_mem_r[wr_ptr_r] <= new_cmd_s;
  end

  // Register file, sticky flags and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steps_r    <= 32'd0;
      period_r   <= 32'd0;
      dir_r      <= 1'b0;
      enable_r   <= 1'b0;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      irq_r      <= 1'b0;
      readdata_r <= 32'd0;
    end else begin
      if (avs_write && (avs_address == 3'd0)) steps_r  <= avs_writedata;
      if (avs_write && (avs_address == 3'd1)) period_r <= avs_writedata;
      if (ctrl_wr_s) begin
        dir_r    <= avs_writedata[0];
        enable_r <= avs_writedata[3];
      end
      irq_en_r <= irq_en_nxt_s;
      if (push_req_s && full_s)                overflow_r <= 1'b1;
      else if (stat_wr_s && avs_writedata[3])  overflow_r <= 1'b0;
      done_r     <= done_nxt_s;
      busy_r     <= (state_nxt != ST_IDLE) || (count_nxt_s != LW'(0));
      irq_r      <= done_nxt_s && irq_en_nxt_s;
      readdata_r <= rd_mux_s;
    end
  end

  assign avs_readdata = readdata_r;
  assign step_out     = step_r;
  assign dir_out      = dir_out_r;
  assign enable_out   = enable_r;
  assign position     = pos_r;
  assign busy         = busy_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Scoreboard bench: a move-level timing model predicts every step rising edge (edge index,
// position, direction); a monitor pops and compares as pulses appear.
module tb_stepper_move_scheduler;
  localparam int PW = 8;
  localparam int DS = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic        step_out, dir_out, enable_out, busy, irq;
  logic [31:0] position;

  stepper_move_scheduler #(.FIFO_DEPTH(4), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .step_out(step_out), .dir_out(dir_out), .enable_out(enable_out), .position(position),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_at;
    logic [31:0] pos;
    logic        dir;
  } exp_t;

  exp_t        sb[$];
  int unsigned pops[$];
  int          checks = 0, errors = 0;
  int unsigned edge_n = 0, wr_edge = 0, next_pop = 0;
  bit          trunc = 1'b0;
  logic [31:0] mpos = 32'd0;
  logic        mdir = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Move-level model: pop when the sequencer is free, optional direction setup, then one
  // rising edge every clamped period; the sequencer idles one cycle before the next pop.
  task automatic model_push(input int unsigned e, input int unsigned steps,
                            input int unsigned per, input logic dir);
    int unsigned pe, p, r;
    pe = (per < 2 * PW) ? 2 * PW : per;
    p  = (e + 1 > next_pop) ? e + 1 : next_pop;
    pops.push_back(p);
    if (steps == 0) begin
      next_pop = p + 1;
    end else begin
      r = p + ((dir != mdir) ? DS : 0);
      mdir = dir;
      for (int k = 0; k < steps; k++) begin
        mpos = dir ? mpos + 32'd1 : mpos - 32'd1;
        sb.push_back('{r + k * pe, mpos, dir});
      end
      next_pop = r + steps * pe + 1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    wr_edge = edge_n;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic push_cmd(input int unsigned steps, input int unsigned per, input logic dir,
                          input logic irq_en, input bit modeled);
    wr(3'd0, steps);
    wr(3'd1, per);
    wr(3'd2, {27'd0, irq_en, 1'b1, 1'b0, 1'b1, dir});
    if (modeled) model_push(wr_edge, steps, per, dir);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy || sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        checks++; errors++;
        $display("FAIL idle_timeout busy %0b pending %0d expected idle", busy, sb.size());
        sb.delete();
        break;
      end
    end
  endtask

  // Monitor: compare each rising edge with the scoreboard head and each pulse width.
  initial begin
    logic prev = 1'b0;
    int unsigned rise_at = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
      #1;
      if (step_out === 1'b1 && !prev) begin
        rise_at = edge_n;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_step at edge %0d got pulse expected none", edge_n);
        end else begin
          e = sb.pop_front();
          chk("rise_edge", edge_n, e.edge_at);
          chk("rise_pos", position, e.pos);
          chk("rise_dir", {31'd0, dir_out}, {31'd0, e.dir});
        end
      end else if (step_out === 1'b0 && prev && !trunc) begin
        chk("pulse_width", edge_n - rise_at, PW);
      end
      prev = (step_out === 1'b1);
    end
  end

  initial begin
    logic [31:0] v;
    int unsigned st, pr, occ, guard;
    logic dr, ie;
    reset_n = 1'b0; avs_address = 3'd0; avs_write = 1'b0; avs_writedata = 32'd0; avs_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {26'd0, step_out, dir_out, enable_out, busy, irq, 1'b0}, 32'd0);
    chk("rst_position", position, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    rd_chk(3'd3, 32'h0000_0004, "status_reset");

    // Three steps with a 0->1 direction change, irq enabled.
    wr(3'd2, 32'h18);
    push_cmd(3, 40, 1'b1, 1'b1, 1'b1);
    wait_idle();
    rd_chk(3'd4, 32'd3, "pos_after_3");
    rd_chk(3'd3, 32'h0000_0014, "status_done");
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h10);
    chk("irq_clear", {31'd0, irq}, 32'd0);

    // Short period is clamped to twice the pulse width.
    push_cmd(2, 5, 1'b1, 1'b0, 1'b1);
    wait_idle();
    rd_chk(3'd4, 32'd5, "pos_after_clamp");

    // Overflow with enable low.
    wr(3'd3, 32'h18);
    wr(3'd2, 32'h01);
    chk("enable_out_low", {31'd0, enable_out}, 32'd0);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd20);
    repeat (5) wr(3'd2, 32'h03);
    rd_chk(3'd3, 32'h0000_040B, "status_overflow");
    wr(3'd3, 32'h08);
    rd_chk(3'd3, 32'h0000_0403, "status_ovf_w1c");
    wr(3'd2, 32'h05);
    rd_chk(3'd3, 32'h0000_0004, "status_flushed");
    chk("no_step_disabled", {31'd0, step_out}, 32'd0);

    // Abort during the high phase of step 2 of 10.
    wr(3'd2, 32'h09);
    chk("enable_out_high", {31'd0, enable_out}, 32'd1);
    wr(3'd4, 32'd0);
    mpos = 32'd0;
    push_cmd(10, 40, 1'b1, 1'b0, 1'b1);
    guard = 0;
    while (!(position == 32'd2 && step_out) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    trunc = 1'b1;
    wr(3'd2, 32'h0D);
    chk("abort_step_low", {31'd0, step_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    sb.delete(); pops.delete();
    next_pop = wr_edge + 1;
    mpos = 32'd2;
    rd_chk(3'd3, 32'h0000_0004, "status_abort");
    rd_chk(3'd4, 32'd2, "pos_abort");
    trunc = 1'b0;

    // Negative move from zero wraps, then a zero-step entry.
    wr(3'd4, 32'd0);
    mpos = 32'd0;
    push_cmd(2, 20, 1'b0, 1'b0, 1'b1);
    wait_idle();
    rd_chk(3'd4, 32'hFFFF_FFFE, "pos_negative");
    wr(3'd3, 32'h10);
    push_cmd(0, 20, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    wait_idle();
    rd_chk(3'd3, 32'h0000_0004, "status_zero_steps");

    // POSITION write on the same edge as a step rising edge.
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd20);
    wr(3'd2, 32'h0A);
    model_push(wr_edge, 1, 20, 1'b0);
    sb[sb.size() - 1].pos = 32'd100;
    mpos = 32'd100;
    wr(3'd4, 32'd100);
    wait_idle();
    rd_chk(3'd4, 32'd100, "pos_write_wins");

    // Randomized command stream.
    for (int i = 0; i < 40; i++) begin
      dr = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 4);
      if (st == 0 && dr != mdir) st = 1;
      pr = $urandom_range(1, 40);
      guard = 0;
      do begin
        while (pops.size() != 0 && pops[0] < edge_n + 1) void'(pops.pop_front());
        occ = pops.size();
        if (occ >= 3) begin
          @(negedge clk);
          guard++;
        end
      end while (occ >= 3 && guard < 5000);
      push_cmd(st, pr, dr, ie, 1'b1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle();
    rd_chk(3'd4, mpos, "pos_random");
    rd(3'd3, v);
    chk("status_random", v & 32'h0000_FF0E, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
